// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin grant mux.
//   DefN / DefW : default requester count and payload width.
//   gnt_state_e : grant controller states.
package rr_pkg;

    localparam int unsigned DefN = 8;
    localparam int unsigned DefW = 8;

    typedef enum logic [0:0] {
        StIdle,
        StWaitGnt
    } gnt_state_e;

endpackage

// File: rtl/rr_req_fifo.sv
// Per-requester FIFO.
//   i_clk, i_rstn : clock, asynchronous active-high reset
//   i_push/i_data : enqueue strobe and payload (dropped when full)
//   i_pop         : dequeue strobe (ignored when empty)
//   o_head        : payload at the head of the queue
//   o_full/o_empty: occupancy flags
module rr_req_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Full is judged on the current occupancy, so a same-cycle pop does not rescue a push.
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end

    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is read until a push has written it.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/rr_grant_mux.sv
// Round-robin grant mux: N request queues, an external registered arbiter,
// and a single registered output stage with valid/ready handshake.
//   i_clk, i_rstn : clock, asynchronous active-high reset
//   i_push/i_data : per-requester enqueue (slice k = bits [k*W +: W])
//   o_full/o_req  : per-queue full / non-empty
//   o_arb_en      : asks the arbiter for a grant (answered on i_gnt next cycle)
//   i_gnt         : registered grant vector, sampled only in StWaitGnt
//   o_valid/o_data/o_src/i_ready : output payload, its source, downstream accept
//   o_err         : sticky flag for a bad grant (zero, multi-hot or empty queue)
module rr_grant_mux
    import rr_pkg::*;
#(
    parameter  int unsigned N     = DefN,
    parameter  int unsigned W     = DefW,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned M     = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic [N-1:0]   i_push,
    input  logic [N*W-1:0] i_data,
    output logic [N-1:0]   o_full,
    output logic [N-1:0]   o_req,
    output logic           o_arb_en,
    input  logic [N-1:0]   i_gnt,
    output logic           o_valid,
    output logic [W-1:0]   o_data,
    output logic [M-1:0]   o_src,
    input  logic           i_ready,
    output logic           o_err
);

    localparam logic [N-1:0] GntOne = {{(N-1){1'b0}}, 1'b1};

    gnt_state_e   state_q, state_d;
    logic [N-1:0] empty;
    logic [N-1:0] pop;
    logic [W-1:0] head [N];
    logic         in_wait, gnt_onehot, gnt_hit, load, err_set, out_free;
    logic [W-1:0] sel_data;
    logic [M-1:0] sel_src;
    logic         valid_q, valid_d;
    logic [W-1:0] data_q;
    logic [M-1:0] src_q;
    logic         err_q;

    for (genvar k = 0; k < N; k++) begin : g_fifo
        rr_req_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rstn  (i_rstn),
            .i_push  (i_push[k]),
            .i_data  (i_data[k*W +: W]),
            .i_pop   (pop[k]),
            .o_head  (head[k]),
            .o_full  (o_full[k]),
            .o_empty (empty[k])
        );
    end

    assign o_req = ~empty;

    // Grant is only meaningful in StWaitGnt; elsewhere it is ignored entirely.
    assign in_wait    = (state_q == StWaitGnt);
    assign gnt_onehot = (i_gnt != '0) && ((i_gnt & (i_gnt - GntOne)) == '0);
    assign gnt_hit    = |(i_gnt & o_req);
    assign load       = in_wait && gnt_onehot && gnt_hit;
    assign err_set    = in_wait && !load;
    assign pop        = load ? i_gnt : '0;
    assign out_free   = !valid_q || i_ready;

    always_comb begin
        state_d  = state_q;
        o_arb_en = 1'b0;
        case (state_q)
            StIdle: begin
                if (|o_req && out_free) begin
                    o_arb_en = 1'b1;
                    state_d  = StWaitGnt;
                end
            end
            StWaitGnt: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Head select; only consulted when the grant is one-hot.
    always_comb begin
        sel_data = '0;
        sel_src  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (i_gnt[k]) begin
                sel_data = head[k];
                sel_src  = M'(k);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (load) begin
                data_q <= sel_data;
                src_q  <= sel_src;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_src   = src_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_rr_grant_mux.sv
module tb_rr_grant_mux;

    localparam int N     = 8;
    localparam int W     = 8;
    localparam int DEPTH = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   i_push = '0;
    logic [N*W-1:0] i_data = '0;
    logic [N-1:0]   o_full, o_req;
    logic           o_arb_en;
    logic [N-1:0]   gnt = '0;
    logic           o_valid;
    logic [W-1:0]   o_data;
    logic [2:0]     o_src;
    logic           i_ready = 1'b1;
    logic           o_err;

    always #5 clk = ~clk;

    rr_grant_mux #(
        .N     (N),
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk    (clk),
        .i_rstn   (rst),
        .i_push   (i_push),
        .i_data   (i_data),
        .o_full   (o_full),
        .o_req    (o_req),
        .o_arb_en (o_arb_en),
        .i_gnt    (gnt),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_src    (o_src),
        .i_ready  (i_ready),
        .o_err    (o_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- external arbiter: round-robin or scripted pattern ----------------
    logic         auto_arb = 1'b1;
    logic [N-1:0] man_pat  = '0;
    int           arb_last = N - 1;
    int           a_idx;
    logic [N-1:0] a_g;

    function automatic int rr_idx(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (last + i) % N;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            gnt <= '0;
            arb_last = N - 1;
        end else if (o_arb_en) begin
            if (auto_arb) begin
                a_idx = rr_idx(o_req, arb_last);
                a_g = '0;
                if (a_idx >= 0) begin
                    a_g[a_idx] = 1'b1;
                    arb_last = a_idx;
                end
                gnt <= a_g;
            end else begin
                gnt <= man_pat;
            end
        end else begin
            gnt <= '0;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int           src;
        logic [W-1:0] data;
    } ent_t;

    ent_t pend_q[$];  // accepted pushes not yet granted
    ent_t out_q[$];   // granted payloads in expected output order
    int   m_occ[N];
    bit   m_wait = 0, m_valid = 0, m_err = 0;

    function automatic bit model_en();
        bit any_r = 0;
        for (int k = 0; k < N; k++) if (m_occ[k] > 0) any_r = 1;
        return !m_wait && any_r && (!m_valid || i_ready);
    endfunction

    function automatic logic [N-1:0] m_req();
        logic [N-1:0] r = '0;
        for (int k = 0; k < N; k++) r[k] = (m_occ[k] > 0);
        return r;
    endfunction

    function automatic logic [N-1:0] m_full();
        logic [N-1:0] r = '0;
        for (int k = 0; k < N; k++) r[k] = (m_occ[k] == DEPTH);
        return r;
    endfunction

    task automatic model_step();
        logic [N-1:0] acc;
        int           gi, idx;
        bit           en;
        ent_t         e;
        if (rst) begin
            for (int k = 0; k < N; k++) m_occ[k] = 0;
            m_wait = 0; m_valid = 0; m_err = 0;
            pend_q.delete();
            out_q.delete();
            return;
        end
        en  = model_en();
        acc = '0;
        for (int k = 0; k < N; k++) if (i_push[k] && m_occ[k] < DEPTH) acc[k] = 1'b1;
        gi = -1;
        if (m_wait && $onehot(gnt)) begin
            for (int k = 0; k < N; k++) if (gnt[k]) gi = k;
            if (m_occ[gi] == 0) gi = -1;
        end
        if (m_wait && gi < 0) m_err = 1;
        if (gi >= 0) begin
            idx = -1;
            for (int i = 0; i < pend_q.size(); i++) if (idx < 0 && pend_q[i].src == gi) idx = i;
            out_q.push_back(pend_q[idx]);
            pend_q.delete(idx);
            m_occ[gi]--;
            m_valid = 1;
        end else if (m_valid && i_ready) begin
            m_valid = 0;
        end
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                e.src  = k;
                e.data = i_data[k*W +: W];
                pend_q.push_back(e);
                m_occ[k]++;
            end
        end
        m_wait = en;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // ---------------- per-cycle monitor (mid-cycle sampling) ----------------
    bit cyc_mode = 0;
    int last_src = -1;
    int n_cons   = 0;

    initial forever begin
        ent_t e;
        @(negedge clk);
        chk("req", o_req, m_req());
        chk("full", o_full, m_full());
        chk("arb_en", o_arb_en, model_en());
        chk("valid", o_valid, m_valid);
        chk("err", o_err, m_err);
        if (!cyc_mode) last_src = -1;
        if (!rst && o_valid && i_ready) begin
            if (out_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: got src %0d data %0h, expected no output", o_src, o_data);
            end else begin
                e = out_q.pop_front();
                chk("sb_src", o_src, e.src);
                chk("sb_data", o_data, e.data);
                if (cyc_mode) begin
                    if (last_src >= 0) chk("rr_order", o_src, (last_src + 1) % N);
                    last_src = o_src;
                    n_cons++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_push = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] push;
        logic [W-1:0] payload;
        logic [N-1:0] pat;
        logic         exp_valid;
        logic [2:0]   exp_src;
        logic         exp_err;
        logic [N-1:0] exp_req;
    } vec_t;

    vec_t vecs[7];
    int   cnt[N];

    initial begin
        vecs[0] = '{8'h08, 8'hA5, 8'h08, 1'b1, 3'd3, 1'b0, 8'h00};
        vecs[1] = '{8'h01, 8'h3C, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00};
        vecs[2] = '{8'h81, 8'h5A, 8'h80, 1'b1, 3'd7, 1'b0, 8'h01};
        vecs[3] = '{8'h06, 8'h77, 8'h00, 1'b0, 3'd0, 1'b1, 8'h06};
        vecs[4] = '{8'h06, 8'h99, 8'h06, 1'b0, 3'd0, 1'b1, 8'h06};
        vecs[5] = '{8'h01, 8'hC3, 8'h02, 1'b0, 3'd0, 1'b1, 8'h01};
        vecs[6] = '{8'hFF, 8'hE1, 8'h10, 1'b1, 3'd4, 1'b0, 8'hEF};

        #1 rst = 1'b1;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_src", o_src, 0);
        chk("rst_err", o_err, 0);
        chk("rst_req", o_req, 0);
        chk("rst_full", o_full, 0);
        chk("rst_arb_en", o_arb_en, 0);
        tick();
        rst = 1'b0;

        // Single transactions with a scripted grant: latency, decode and errors.
        foreach (vecs[v]) begin
            do_reset();
            auto_arb = 1'b0;
            man_pat  = vecs[v].pat;
            i_ready  = 1'b1;
            i_push   = vecs[v].push;
            i_data   = {N{vecs[v].payload}};
            tick();                       // edge 1: enqueue
            i_push = '0;
            tick();                       // edge 2: enable taken, grant registered
            chk($sformatf("v%0d_pre_valid", v), o_valid, 0);
            tick();                       // edge 3: grant load
            @(negedge clk);
            chk($sformatf("v%0d_valid", v), o_valid, vecs[v].exp_valid);
            chk($sformatf("v%0d_err", v), o_err, vecs[v].exp_err);
            chk($sformatf("v%0d_req", v), o_req, vecs[v].exp_req);
            if (vecs[v].exp_valid) begin
                chk($sformatf("v%0d_src", v), o_src, vecs[v].exp_src);
                chk($sformatf("v%0d_data", v), o_data, vecs[v].payload);
            end
        end

        // Queue 0 full: third push dropped even though a pop happens that edge.
        do_reset();
        auto_arb = 1'b1;
        i_ready  = 1'b0;
        i_push   = 8'h01;
        i_data   = '0;
        i_data[7:0] = 8'h11;
        tick();
        i_data[7:0] = 8'h22;
        tick();
        i_data[7:0] = 8'h33;
        @(negedge clk);
        chk("fill_full0", o_full[0], 1);
        tick();
        i_push = '0;
        @(negedge clk);
        chk("fill_full0_after_pop", o_full[0], 0);
        chk("fill_first", o_data, 8'h11);
        chk("fill_req0", o_req[0], 1);
        tick();
        i_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("fill_second", o_data, 8'h22);
        chk("fill_second_src", o_src, 0);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("fill_no_third", o_valid, 0);

        // Backpressure holds the output and blocks arbitration.
        do_reset();
        auto_arb = 1'b1;
        i_ready  = 1'b0;
        i_push   = 8'h06;
        i_data   = '0;
        i_data[15:8]  = 8'h31;
        i_data[23:16] = 8'h42;
        tick();
        i_push = '0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_arb_en", o_arb_en, 0);
            chk("bp_data", o_data, 8'h31);
            chk("bp_src", o_src, 1);
            tick();
        end
        i_ready = 1'b1;
        @(negedge clk);
        chk("bp_arb_en_ready", o_arb_en, 1);
        tick();
        tick();
        @(negedge clk);
        chk("bp_next_valid", o_valid, 1);
        chk("bp_next_data", o_data, 8'h42);
        chk("bp_next_src", o_src, 2);

        // Bad grants: zero, then multi-hot; error is sticky across a good load.
        do_reset();
        auto_arb = 1'b0;
        man_pat  = 8'h00;
        i_ready  = 1'b1;
        i_push   = 8'h06;
        i_data   = {N{8'h5C}};
        tick();
        i_push = '0;
        tick();
        tick();
        man_pat = 8'h06;
        @(negedge clk);
        chk("bad0_err", o_err, 1);
        chk("bad0_req", o_req, 8'h06);
        chk("bad0_valid", o_valid, 0);
        tick();
        tick();
        man_pat = 8'h02;
        @(negedge clk);
        chk("bad6_err", o_err, 1);
        chk("bad6_req", o_req, 8'h06);
        chk("bad6_valid", o_valid, 0);
        tick();
        tick();
        @(negedge clk);
        chk("bad_then_good_valid", o_valid, 1);
        chk("bad_then_good_src", o_src, 1);
        chk("bad_sticky_err", o_err, 1);
        chk("bad_then_good_req", o_req, 8'h04);
        do_reset();
        @(negedge clk);
        chk("err_cleared_by_reset", o_err, 0);

        // Reset while waiting for a grant with queue 5 full.
        auto_arb = 1'b0;
        man_pat  = 8'h20;
        i_push   = 8'h20;
        i_data   = {N{8'h5A}};
        tick();
        i_data = {N{8'h5B}};
        tick();
        i_push = '0;
        chk("wrst_pre_req", o_req, 8'h20);
        chk("wrst_pre_full", o_full, 8'h20);
        #2 rst = 1'b1;
        #1;
        chk("wrst_req", o_req, 0);
        chk("wrst_valid", o_valid, 0);
        chk("wrst_err", o_err, 0);
        chk("wrst_arb_en", o_arb_en, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("wrst_after_valid", o_valid, 0);
        chk("wrst_after_err", o_err, 0);

        // All queues kept full against the round-robin arbiter.
        do_reset();
        auto_arb = 1'b1;
        i_ready  = 1'b1;
        cyc_mode = 1;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        for (int c = 0; c < 300; c++) begin
            i_push = '0;
            for (int k = 0; k < N; k++) begin
                if (m_occ[k] < DEPTH) begin
                    i_push[k] = 1'b1;
                    i_data[k*W +: W] = W'((k << 5) | (cnt[k] & 31));
                    cnt[k]++;
                end
            end
            tick();
        end
        i_push   = '0;
        cyc_mode = 0;
        chk("rr_throughput", (n_cons >= 140), 1);
        repeat (40) tick();
        @(negedge clk);
        chk("drain_valid", o_valid, 0);
        chk("drain_req", o_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
